// File: rtl/cnn_frame_ctrl.sv
// cnn_frame_ctrl: flushes the CNN pipeline, streams one image from pixel RAM into conv1
// and latches the comparator decision. Define CNN_CTRL_TIMEOUT_EN to enable the WAIT watchdog.
module cnn_frame_ctrl #(
   parameter int PIX_NUM        = 784,
   parameter int ADDR_W         = 10,
   parameter int PIX_W          = 8,
   parameter int FLUSH_CYCLES   = 2,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [3:0]        result,
   output logic              timeout,
   output logic [15:0]       frame_cnt,
   output logic              img_rd_en,
   output logic [ADDR_W-1:0] img_addr,
   input  logic [PIX_W-1:0]  img_rdata,
   output logic [PIX_W-1:0]  pix_out,
   output logic              pix_valid,
   output logic              pipe_rst_n,
   input  logic              dec_valid,
   input  logic [3:0]        dec_in
);

   typedef enum logic [2:0] {IDLE, FLUSH, STREAM, WAIT, DONE} state_t;

   localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam int WT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(PIX_NUM - 1);
   localparam logic [FC_W-1:0]   FLUSH_LOAD = FC_W'(FLUSH_CYCLES - 1);
   localparam logic [WT_W-1:0]   WAIT_LAST  = WT_W'(TIMEOUT_CYCLES - 1);

`ifdef CNN_CTRL_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   state_t            state, state_next;
   logic [FC_W-1:0]   flush_cnt;
   logic [WT_W-1:0]   wait_cnt;
   logic              wait_expired;
   logic              timeout_r;
   logic              dec_vld_p0;
   logic [3:0]        dec_p0;
   logic              vld_p0;

   // Without the watchdog these fold to constants: WAIT never expires, timeout stays 0
   assign wait_expired = TO_EN && (wait_cnt == WAIT_LAST);
   assign timeout      = TO_EN && timeout_r;

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = FLUSH;
         FLUSH:   if (flush_cnt == '0) state_next = STREAM;
         STREAM:  if (img_addr == ADDR_LAST) state_next = WAIT;
         WAIT:    if (dec_vld_p0 || wait_expired) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         result     <= '0;
         timeout_r  <= 1'b0;
         frame_cnt  <= '0;
         img_rd_en  <= 1'b0;
         img_addr   <= '0;
         pipe_rst_n <= 1'b0;
         flush_cnt  <= '0;
         wait_cnt   <= '0;
         dec_vld_p0 <= 1'b0;
         vld_p0     <= 1'b0;
         pix_valid  <= 1'b0;
         pix_out    <= '0;
      end else begin
         state      <= state_next;
         busy       <= (state_next == FLUSH) || (state_next == STREAM) || (state_next == WAIT);
         pipe_rst_n <= (state_next != FLUSH);
         img_rd_en  <= (state_next == STREAM);
         done       <= (state_next == DONE);
         img_addr   <= (state == STREAM && state_next == STREAM) ? img_addr + 1'b1 : '0;
         flush_cnt  <= (state == FLUSH) ? flush_cnt - 1'b1 : FLUSH_LOAD;
         wait_cnt   <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
         // Decision stage p0: only a dec_valid seen in WAIT can complete the frame
         dec_vld_p0 <= dec_valid && (state == WAIT);
         if (state == IDLE && start)
            timeout_r <= 1'b0;
         if (state == WAIT && state_next == DONE) begin
            frame_cnt <= frame_cnt + 16'd1;
            result    <= dec_vld_p0 ? dec_p0 : 4'hF;
            timeout_r <= !dec_vld_p0;
         end
         // Read stage p0 covers RAM latency; pix_valid/pix_out form stage p1
         vld_p0    <= img_rd_en;
         pix_valid <= vld_p0;
         pix_out   <= vld_p0 ? img_rdata : '0;
      end
   end

   always_ff @(posedge clk) begin
      dec_p0 <= dec_in;
   end

endmodule
